// File: rtl/inv_pkg.sv
// Shared constants and types for the inverter block and its edge detector.
package inv_pkg;

   localparam int unsigned CntWDefault = 16;

   typedef logic [CntWDefault-1:0] cnt_t;

   // Saturating +1 for a counter of arbitrary width held in a 32-bit container.
   function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max_val);
      return (val >= max_val) ? max_val : val + 1;
   endfunction

endpackage

// File: rtl/inv_edge_det.sv
// Registered per-bit rise/fall detector: compares current data with its previous sample.
module inv_edge_det
   import inv_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] a_prev,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] rise_d, rise_q;
   logic [WIDTH-1:0] fall_d, fall_q;

   always_comb begin
      rise_d = a & ~a_prev;
      fall_d = ~a & a_prev;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/inv.sv
// Inverter with registered copy, per-bit edge pulses and a saturating toggle counter.
module inv
   import inv_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic             clr_cnt,
   output logic [WIDTH-1:0] b_q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             cnt_sat
);

   logic [WIDTH-1:0] b_q_d, b_q_q;
   logic [WIDTH-1:0] a_prev_d, a_prev_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             changed;
   logic             at_max;

   // Zero-latency path; deliberately independent of clk and rst.
   assign b = ~a;

   always_comb begin
      b_q_d    = ~a;
      a_prev_d = a;
      changed  = |(a ^ a_prev_q);
      at_max   = &cnt_q;
      cnt_d    = cnt_q;
      // Clear wins over a same-cycle increment; one count per cycle regardless of bits changed.
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (changed && !at_max) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         b_q_q    <= '1;
         a_prev_q <= '0;
         cnt_q    <= '0;
      end else begin
         b_q_q    <= b_q_d;
         a_prev_q <= a_prev_d;
         cnt_q    <= cnt_d;
      end
   end

   inv_edge_det #(
      .WIDTH (WIDTH)
   ) u_edge_det (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .a_prev (a_prev_q),
      .rise   (rise),
      .fall   (fall)
   );

   assign b_q        = b_q_q;
   assign toggle_cnt = cnt_q;
   assign cnt_sat    = &cnt_q;

endmodule

// File: tb/tb_inv.sv
// Randomized check of two inv instances (4-bit/3-bit counter and 1-bit/16-bit counter).
module tb_inv;

   logic        clk;
   logic        rst;
   logic        clr_cnt;
   logic [3:0]  a4, b4, bq4, rise4, fall4;
   logic [2:0]  cnt4;
   logic        sat4;
   logic        a1, b1, bq1, rise1, fall1;
   logic [15:0] cnt1;
   logic        sat1;

   int n_chk  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   // Behavioural model state, index 0 = 4-bit instance, 1 = 1-bit instance.
   int unsigned m_mask[2] = '{15, 1};
   int unsigned m_max[2]  = '{7, 65535};
   int unsigned m_prev[2];
   int unsigned m_bq[2];
   int unsigned m_rise[2];
   int unsigned m_fall[2];
   int unsigned m_cnt[2];

   inv #(
      .WIDTH (4),
      .CNT_W (3)
   ) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .a          (a4),
      .b          (b4),
      .clr_cnt    (clr_cnt),
      .b_q        (bq4),
      .rise       (rise4),
      .fall       (fall4),
      .toggle_cnt (cnt4),
      .cnt_sat    (sat4)
   );

   inv #(
      .WIDTH (1),
      .CNT_W (16)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .a          (a1),
      .b          (b1),
      .clr_cnt    (clr_cnt),
      .b_q        (bq1),
      .rise       (rise1),
      .fall       (fall1),
      .toggle_cnt (cnt1),
      .cnt_sat    (sat1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         int unsigned ain;
         ain = (k == 0) ? 32'(a4) : 32'(a1);
         if (rst) begin
            m_bq[k]   = m_mask[k];
            m_prev[k] = 0;
            m_rise[k] = 0;
            m_fall[k] = 0;
            m_cnt[k]  = 0;
         end else begin
            m_rise[k] = ain & ~m_prev[k] & m_mask[k];
            m_fall[k] = ~ain & m_prev[k] & m_mask[k];
            m_bq[k]   = ~ain & m_mask[k];
            if (clr_cnt) m_cnt[k] = 0;
            else if (ain != m_prev[k]) m_cnt[k] = inv_pkg::sat_inc(m_cnt[k], m_max[k]);
            m_prev[k] = ain;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("b4", 32'(b4), ~32'(a4) & m_mask[0]);
         chk("b_q4", 32'(bq4), m_bq[0]);
         chk("rise4", 32'(rise4), m_rise[0]);
         chk("fall4", 32'(fall4), m_fall[0]);
         chk("cnt4", 32'(cnt4), m_cnt[0]);
         chk("sat4", 32'(sat4), 32'(m_cnt[0] == m_max[0]));
         chk("b1", 32'(b1), ~32'(a1) & m_mask[1]);
         chk("b_q1", 32'(bq1), m_bq[1]);
         chk("rise1", 32'(rise1), m_rise[1]);
         chk("fall1", 32'(fall1), m_fall[1]);
         chk("cnt1", 32'(cnt1), m_cnt[1]);
         chk("sat1", 32'(sat1), 32'(m_cnt[1] == m_max[1]));
      end
   end

   initial begin
      rst     = 1'b1;
      clr_cnt = 1'b0;
      a4      = 4'b0000;
      a1      = 1'b0;
      #1;
      chk("lit_b1_a0", 32'(b1), 32'd1);
      a1 = 1'b1;
      #1;
      chk("lit_b1_a1", 32'(b1), 32'd0);
      chk("lit_b4_a0", 32'(b4), 32'hF);

      // Two reset cycles with a1 held high.
      tick();
      check_en = 1'b1;
      tick();
      chk("lit_rst_bq1", 32'(bq1), 32'd1);
      chk("lit_rst_cnt1", 32'(cnt1), 32'd0);
      chk("lit_rst_rise1", 32'(rise1), 32'd0);
      chk("lit_rst_b1", 32'(b1), 32'd0);
      rst = 1'b0;

      tick();
      chk("lit_rel_rise1", 32'(rise1), 32'd1);
      chk("lit_rel_cnt1", 32'(cnt1), 32'd1);
      chk("lit_rel_bq1", 32'(bq1), 32'd0);
      a4 = 4'b1010;
      tick();
      chk("lit_rise4_a", 32'(rise4), 32'hA);
      chk("lit_fall4_a", 32'(fall4), 32'h0);
      chk("lit_cnt4_a", 32'(cnt4), 32'd1);
      chk("lit_rise1_once", 32'(rise1), 32'd0);
      a4 = 4'b0110;
      tick();
      chk("lit_rise4_b", 32'(rise4), 32'h4);
      chk("lit_fall4_b", 32'(fall4), 32'h8);
      chk("lit_cnt4_b", 32'(cnt4), 32'd2);

      for (int i = 0; i < 10; i++) begin
         a4 = ~a4;
         tick();
      end
      chk("lit_sat_cnt4", 32'(cnt4), 32'd7);
      chk("lit_sat_flag4", 32'(sat4), 32'd1);

      // Clear coincident with a full toggle.
      a4      = ~a4;
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("lit_clr_cnt4", 32'(cnt4), 32'd0);
      chk("lit_clr_edges4", 32'(rise4 | fall4), 32'hF);
      chk("lit_clr_cnt1", 32'(cnt1), 32'd0);

      // Reset one cycle after an edge is sampled.
      a4 = a4 ^ 4'b0101;
      tick();
      rst = 1'b1;
      tick();
      chk("lit_mid_rise4", 32'(rise4), 32'd0);
      chk("lit_mid_fall4", 32'(fall4), 32'd0);
      chk("lit_mid_cnt4", 32'(cnt4), 32'd0);
      chk("lit_mid_bq4", 32'(bq4), 32'hF);
      rst = 1'b0;

      for (int i = 0; i < 400; i++) begin
         a4      = 4'($urandom);
         a1      = 1'($urandom);
         clr_cnt = ($urandom_range(0, 9) == 0);
         rst     = ($urandom_range(0, 39) == 0);
         tick();
      end
      rst     = 1'b0;
      clr_cnt = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inv.md
INV -- requirements
Module: inv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the bit width of the data path.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the toggle-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port a, input, WIDTH bits, the data to invert.
REQ-006 The block SHALL have port b, output, WIDTH bits, the combinational inverse of a.
REQ-007 The block SHALL have port clr_cnt, input, 1 bit, a synchronous clear of the toggle counter.
REQ-008 The block SHALL have port b_q, output, WIDTH bits, the registered inverse of a.
REQ-009 The block SHALL have port rise, output, WIDTH bits, a per-bit one-cycle pulse when a goes from 0 to 1.
REQ-010 The block SHALL have port fall, output, WIDTH bits, a per-bit one-cycle pulse when a goes from 1 to 0.
REQ-011 The block SHALL have port toggle_cnt, output, CNT_W bits, the count of sampled cycles in which a changed.
REQ-012 The block SHALL have port cnt_sat, output, 1 bit, high while toggle_cnt equals all ones.

Function
REQ-013 b SHALL equal bitwise NOT a at all times, with zero latency and independent of clk and rst.
REQ-014 b_q SHALL load NOT a on every rising clk edge when rst is low, giving one cycle of latency.
REQ-015 The block SHALL keep a_prev, a register of a sampled each cycle.
REQ-016 rise[i] SHALL equal a[i] AND NOT a_prev[i], and this SHALL be registered so that it asserts for exactly one cycle, the cycle after the edge is sampled.
REQ-017 fall[i] SHALL equal NOT a[i] AND a_prev[i], registered with the same timing as rise.
REQ-018 toggle_cnt SHALL increment by 1 in each cycle where a differs from a_prev in any bit; it counts one per cycle, not one per bit.
REQ-019 toggle_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 cnt_sat SHALL be the combinational decode of toggle_cnt equal to all ones.
REQ-021 When clr_cnt is high, toggle_cnt SHALL become 0 on the next edge; clr_cnt SHALL take priority over a simultaneous increment.
REQ-022 clr_cnt SHALL NOT affect b, b_q, rise, fall or a_prev.
REQ-023 A glitch on a between clock edges SHALL affect only b; registered outputs reflect only values sampled at edges.

Reset
REQ-024 While rst is high at a clk edge, the block SHALL set b_q to all ones, a_prev to 0, rise to 0, fall to 0 and toggle_cnt to 0.
REQ-025 Reset SHALL take priority over clr_cnt and over counting.
REQ-026 b SHALL keep tracking NOT a during reset.
REQ-027 After reset releases, if a is nonzero in the first sampled cycle, that cycle SHALL count as a toggle and raise rise for the set bits, because a_prev resets to 0.
REQ-028 Reset asserted mid-operation SHALL discard any pending rise or fall pulse and the counter value.

Structure
REQ-029 Package inv_pkg SHALL hold the CNT_W default constant and the counter typedef.
REQ-030 Per-bit edge detection SHALL live in one sub-module, inv_edge_det, which takes clk, rst, the data and a_prev and produces rise and fall; inv instantiates it once at width WIDTH.
REQ-031 All other logic SHALL be in inv, with no latches and a single clock domain.

Verification
REQ-032 With WIDTH=1: a=0 -> b=1 immediately; at 10 ns a=1 -> b=0 immediately, with b_q=0 after the next edge; finish at 30 ns.
REQ-033 Hold rst high 2 cycles with a=1 -> b_q=1, toggle_cnt=0, rise=0, and b=0 throughout; release rst -> rise=1 for one cycle, toggle_cnt=1.
REQ-034 With WIDTH=4, a goes 0000 to 1010 to 0110 on consecutive edges -> rise 1010 then 0100, fall 0000 then 1000, toggle_cnt +2.
REQ-035 With CNT_W=3, toggle a every cycle for 10 cycles -> toggle_cnt stops at 7, cnt_sat=1, no wrap.
REQ-036 Assert clr_cnt in the same cycle as a toggle -> toggle_cnt=0 next cycle, and rise/fall still pulse.
REQ-037 Assert rst one cycle after an a edge -> no rise/fall pulse appears, toggle_cnt=0.
